// File: rtl/riscv_fetch_pkg.sv
// Shared types for the instruction fetch front end.
//   fetch_state_t : controller FSM states (IDLE, RUN, FAULT)
//   fetch_entry_t : one buffered fetch, the word plus the PC it came from
//   INSTR_BYTES   : fetch stride in bytes
`timescale 1ns/1ps
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small circular FIFO of fetch entries between the fetch PC and decode.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   push, tail      : write tail entry (caller guarantees !full or a same-cycle pop)
//   pop             : drop the head entry (caller guarantees !empty)
//   flush           : discard every entry; has priority over push/pop
//   count/full/empty: occupancy
//   head            : oldest entry; reads the reset value 0 until first write
`timescale 1ns/1ps
module fetch_buffer
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  tail,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output fetch_entry_t  head
);

  fetch_entry_t  entries [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        entries[tail_ptr] <= tail;
        tail_ptr          <= tail_ptr + 1'b1;
      end
      if (pop) head_ptr <= head_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = entries[head_ptr];

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: owns the fetch PC, drives the combinational
// instruction memory, buffers returned words and hands them to decode.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   en                 : fetch enable
//   imem_pc/imem_instr : memory address out, same-cycle word back
//   redirect_valid/pc  : taken branch/jump target (highest priority)
//   out_valid/out_ready: head handshake to decode
//   out_pc/out_instr   : head entry; out_pc_plus4 = out_pc + 4 (mod 2^32)
//   fault              : sticky misaligned-redirect flag, cleared only by reset
//   fetch_count        : number of accepted handshakes (wraps)
`timescale 1ns/1ps
module fetch_controller
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc_plus4,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam int          CW   = $clog2(DEPTH) + 1;
  localparam logic [31:0] STEP = 32'(INSTR_BYTES);

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   fetch_pc;
  logic          push;
  logic          pop;
  logic          flush;
  logic          misaligned;
  logic          take_redirect;
  logic [CW-1:0] buf_count;
  logic          buf_full;
  logic          buf_empty;
  fetch_entry_t  head;
  fetch_entry_t  tail;

  // Redirects are dead once faulted; only reset leaves FAULT.
  assign misaligned    = (redirect_pc[1:0] != 2'b00);
  assign take_redirect = redirect_valid && (state != FAULT);
  assign tail          = '{pc: fetch_pc, instr: imem_instr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, RUN: begin
        if (take_redirect && misaligned) state_next = FAULT;
        else                             state_next = en ? RUN : IDLE;
      end
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
  end

  // Any redirect flushes the buffer; a pop in the same cycle still counts
  // because decode already consumed the head. A full buffer may only take
  // a new word when the head leaves in the same cycle.
  always_comb begin
    out_valid = !buf_empty && (state != FAULT);
    fault     = (state == FAULT);
    pop       = out_valid && out_ready;
    flush     = take_redirect;
    push      = (state == RUN) && en && !redirect_valid && (!buf_full || pop);
  end

  // A misaligned target leaves fetch_pc untouched so the faulting context
  // stays visible on imem_pc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            fetch_pc <= RESET_PC;
    else if (take_redirect && !misaligned) fetch_pc <= redirect_pc;
    else if (push)                        fetch_pc <= fetch_pc + STEP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    fetch_count <= '0;
    else if (pop) fetch_count <= fetch_count + 32'd1;
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .tail  (tail),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty),
    .head  (head)
  );

  assign imem_pc      = fetch_pc;
  assign out_pc       = head.pc;
  assign out_instr    = head.instr;
  assign out_pc_plus4 = head.pc + STEP;

  occupancy_consistent: assert property (
    @(posedge clk) disable iff (reset) ((buf_count == '0) == buf_empty)
  );

endmodule
